data_memory: RTL and testbench

- Byte-addressed, little-endian 32-bit data memory for the pipelined RISC datapath's MEM stage, next to the forwarding unit.
- Writes are synchronous on the clock.
- Reads are combinational, gated by mem_read.
- The whole array clears to zero on reset.

---
 rtl/data_memory_pkg.sv | 36 +++
 rtl/data_memory_if.sv | 27 ++
 rtl/data_memory.sv | 64 ++++++
 tb/tb_data_memory.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and byte-lane helpers for the MEM-stage data memory.
// Words are little-endian: lane 0 holds bits 7:0 and sits at the lowest byte address.
package data_memory_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  // Extract one byte lane of a word; lane 0 = bits 7:0.
  function automatic byte_t word_lane(input word_t w, input logic [1:0] lane);
    byte_t b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Place a byte into its lane of an otherwise-zero word.
  function automatic word_t lane_word(input byte_t b, input logic [1:0] lane);
    word_t w;
    case (lane)
      2'd0:    w = {24'h000000, b};
      2'd1:    w = {16'h0000, b, 8'h00};
      2'd2:    w = {8'h00, b, 16'h0000};
      2'd3:    w = {b, 24'h000000};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store port between the MEM stage (master) and the data memory (slave).
interface data_memory_if;
  import data_memory_pkg::*;

  word_t address;
  word_t write_data;
  logic  mem_read;
  logic  mem_write;
  word_t read_data;

  modport master (
    output address,
    output write_data,
    output mem_read,
    output mem_write,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  mem_read,
    input  mem_write,
    output read_data
  );

endinterface

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory: synchronous word writes, combinational
// gated word reads, any alignment, byte index wraps modulo the depth.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  localparam int DEPTH = 32'd1 << ADDR_BITS;

  typedef logic [ADDR_BITS-1:0] idx_t;

  byte_t                 mem_r [DEPTH];
  idx_t                  lane_idx_s [BYTES_PER_WORD];
  logic [DATA_WIDTH-1:0] read_data_s;
  logic                  unused_addr_s;

  // Upper address bits alias onto the same storage.
  assign unused_addr_s = ^bus.address[31:ADDR_BITS];

  // Byte index of each lane; idx_t arithmetic gives the wrap at top of memory.
  always_comb begin
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      lane_idx_s[l] = bus.address[ADDR_BITS-1:0] + idx_t'(l);
    end
  end

  // Byte array: asynchronous clear, otherwise four-lane word store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (bus.mem_write) begin
      for (int l = 0; l < BYTES_PER_WORD; l++) begin
        mem_r[lane_idx_s[l]] <= word_lane(bus.write_data, 2'(l));
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i];
      end
    end
  end

  // Zero-latency read; no bypass, so a same-cycle write shows up after the edge.
  always_comb begin
    read_data_s = 32'h0000_0000;
    if (bus.mem_read) begin
      for (int l = 0; l < BYTES_PER_WORD; l++) begin
        read_data_s = read_data_s | lane_word(mem_r[lane_idx_s[l]], 2'(l));
      end
    end else begin
      read_data_s = 32'h0000_0000;
    end
  end

  assign bus.read_data = read_data_s;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed steps plus randomized traffic
// compared against a flat byte-array reference model.
module tb_data_memory;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] ref_mem [256];

  data_memory_if bus ();

  data_memory #(.ADDR_BITS(8), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d);
    int base;
    base = int'(a % 32'd256);
    for (int k = 0; k < 4; k++) ref_mem[(base + k) % 256] = 8'((d >> (8 * k)) & 32'hFF);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic rd);
    int base;
    logic [31:0] w;
    w = 32'h0;
    if (!rd) return 32'h0;
    base = int'(a % 32'd256);
    for (int k = 0; k < 4; k++) w = w | (32'(ref_mem[(base + k) % 256]) << (8 * k));
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] expected);
    checks++;
    assert (bus.read_data === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, bus.read_data, expected);
      end
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic rd);
    bus.address  = a;
    bus.mem_read = rd;
    #1;
    check(tag, ref_read(a, rd));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    @(posedge clk);
    if (rst_n) ref_write(a, d);
    #1;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    checks = 0;
    errors = 0;
    ref_clear();
    rst_n          = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    read_chk("reset_addr0", 32'd0, 1'b1);
    read_chk("reset_addr252", 32'd252, 1'b1);
    check("reset_literal", 32'h0000_0000);

    // Aligned write / read
    do_write(32'd8, 32'd45);
    read_chk("aligned_8", 32'd8, 1'b1);
    check("aligned_8_literal", 32'h0000_002D);

    // Unaligned reads
    read_chk("unaligned_9_before", 32'd9, 1'b1);
    do_write(32'd12, 32'hA1B2_C3D4);
    read_chk("unaligned_9", 32'd9, 1'b1);
    check("unaligned_9_literal", 32'hD400_0000);
    read_chk("unaligned_10", 32'd10, 1'b1);
    check("unaligned_10_literal", 32'hC3D4_0000);
    read_chk("aligned_12", 32'd12, 1'b1);

    // Read gating, combinational re-enable
    read_chk("gated_8", 32'd8, 1'b0);
    read_chk("ungated_8", 32'd8, 1'b1);

    // Wrap and aliasing
    do_write(32'd254, 32'h1122_3344);
    read_chk("wrap_0", 32'd0, 1'b1);
    check("wrap_0_literal", 32'h0000_1122);
    read_chk("wrap_254", 32'd254, 1'b1);
    read_chk("wrap_255", 32'd255, 1'b1);
    read_chk("alias_108", 32'h108, 1'b1);
    read_chk("alias_hi", 32'hFFFF_FF08, 1'b1);

    // Read-during-write on overlapping bytes
    @(negedge clk);
    bus.address    = 32'd10;
    bus.mem_read   = 1'b1;
    bus.write_data = 32'h5566_7788;
    bus.mem_write  = 1'b1;
    #1;
    check("rdw_before", ref_read(32'd10, 1'b1));
    @(posedge clk);
    ref_write(32'd10, 32'h5566_7788);
    #1;
    bus.mem_write = 1'b0;
    check("rdw_after", ref_read(32'd10, 1'b1));

    // Reset mid-operation
    do_write(32'd16, 32'hDEAD_BEEF);
    read_chk("pre_reset_16", 32'd16, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ref_clear();
    #1;
    check("async_clear_16", 32'h0000_0000);
    read_chk("async_clear_12", 32'd12, 1'b1);
    do_write(32'd20, 32'hCAFE_F00D);
    read_chk("write_in_reset", 32'd20, 1'b1);
    // Write pending when reset hits before its edge
    @(negedge clk);
    rst_n = 1'b1;
    bus.address    = 32'd24;
    bus.write_data = 32'h1234_5678;
    bus.mem_write  = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    read_chk("reset_mid_write", 32'd24, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    read_chk("post_reset_24", 32'd24, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FF07;
        do_write(a, d);
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'h0000_000F;
      read_chk("random_read", a, 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
